uart_rx_sampler: RTL and testbench

- UART 8N1 receiver and the receive-side counterpart of the baud pulse generator used by the transmit path.
- Owns a mid-bit sampling counter and emits one received byte plus a single-cycle valid strobe.
- Sits between the board RX pin and the LED/command logic.
- Reports framing errors.
- Parity checking is available as a compile-time option.

---
 rtl/uart_rx_sampler_if.sv | 22 ++
 rtl/uart_rx_sampler.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: serial line input plus received-byte/status outputs
// of the UART receiver.
// master: the side that drives the line and consumes the results.
// slave: the receiver itself.
interface uart_rx_sampler_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_busy;

  modport master (
    output rx,
    input  rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_busy
  );

  modport slave (
    input  rx,
    output rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_busy
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: UART 8N1 receiver with mid-bit sampling.
// The start bit is confirmed at its midpoint. Every later bit is sampled
// one full bit time after the previous sample. The frame ends at
// mid-stop-bit, so a back-to-back start bit is caught with half a bit of margin.
// Compile-time option: define UART_RX_PARITY_EN for 8E1 (even parity) framing.
// Legal range: 4 <= CLK_FREQ/BAUD_RATE <= 65535 (the counter is 16 bits).
module uart_rx_sampler #(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_rx_sampler_if.slave  bus
);
  // Derived timing constants; these are not meant to be overridden.
  localparam int          CYCLE_PER_BAUD = CLK_FREQ / BAUD_RATE;
  localparam int          HALF_BAUD      = CYCLE_PER_BAUD / 2;
  localparam logic [15:0] BIT_LAST       = 16'(CYCLE_PER_BAUD - 1);
  localparam logic [15:0] HALF_LAST      = 16'(HALF_BAUD - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        frame_err_q;
  logic        busy_q;
  logic [1:0]  sync_q;
  logic        rx_s;
`ifdef UART_RX_PARITY_EN
  logic        parity_err_q;
  logic        par_pend_q;
`endif

  assign rx_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous line; it resets to the idle level.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], bus.rx};
  end

  // Receive FSM. The counter, shift register and strobes are all registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_pend_q   <= 1'b0;
`endif
    end else begin
      // Strobes default low so that each one lasts a single cycle.
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_pend_q <= 1'b0;
`endif
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              // The line went high again before mid-start: treat it as a glitch.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rx_s;
            bit_idx_q          <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q      <= '0;
            state_q    <= STOP;
            // Even parity: the parity bit must equal the XOR of the data bits.
            par_pend_q <= (rx_s != ^shift_q);
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`endif
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!rx_s) begin
              frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_pend_q) begin
              parity_err_q <= 1'b1;
`endif
            end else begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_frame_err = frame_err_q;
  assign bus.rx_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.rx_parity_err = parity_err_q;
`else
  assign bus.rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: drives serial frames bit by bit and checks each
// frame's strobe kind, data and latency against a frame-level model.
// A directed table runs first, then a few hand-written sequences and then random frames.
`timescale 1ns/1ps
module tb_uart_rx_sampler;
  localparam int CLK_FREQ  = 25000000;
  localparam int BAUD_RATE = 115200;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Nominal start-edge-to-strobe latency; one cycle of tolerance either way.
  localparam int LAT_NOM = 2 + HALF + (NBITS - 1) * CPB + 1;
  localparam int K_VALID = 1;
  localparam int K_FERR  = 2;
  localparam int K_PERR  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_rx_sampler_if bus();

  uart_rx_sampler #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;
  ev_t evq[$];

  bit busy_watch = 1'b0;
  int busy_drops = 0;

  // Record every strobe cycle; sampling is done on the falling edge.
  always @(negedge clk) begin
    ev_t e;
    e.data = bus.rx_data;
    e.cyc  = cyc;
    if (bus.rx_valid === 1'b1)      begin e.kind = K_VALID; evq.push_back(e); end
    if (bus.rx_frame_err === 1'b1)  begin e.kind = K_FERR;  evq.push_back(e); end
    if (bus.rx_parity_err === 1'b1) begin e.kind = K_PERR;  evq.push_back(e); end
    if (busy_watch && bus.rx_busy !== 1'b1) busy_drops = busy_drops + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int last_valid_cyc = 0;
  logic [7:0] model_last = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " rx_data"},       32'(bus.rx_data), 32'h0);
    chk({tag, " rx_valid"},      32'(bus.rx_valid), 32'h0);
    chk({tag, " rx_frame_err"},  32'(bus.rx_frame_err), 32'h0);
    chk({tag, " rx_parity_err"}, 32'(bus.rx_parity_err), 32'h0);
    chk({tag, " rx_busy"},       32'(bus.rx_busy), 32'h0);
  endtask

  // Every task below is entered and left at 1 time unit after a rising edge.
  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                            input int gap, input bit watch, output int e0);
    e0 = cyc + 1;  // first edge that sees the start bit
    drive_bit(1'b0);
    busy_watch = watch;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_ok ? ^d : ~^d);
`endif
    busy_watch = 1'b0;
    drive_bit(stop_ok);
    for (int i = 0; i < gap; i++) drive_bit(1'b1);
  endtask

  task automatic check_frame(input string name, input int e0, input int exp_kind,
                             input logic [7:0] exp_data, input bit chk_sp);
    chk({name, " strobe_count"}, 32'(evq.size()), 32'd1);
    if (evq.size() > 0) begin
      chk({name, " kind"}, 32'(evq[0].kind), 32'(exp_kind));
      chk({name, " rx_data"}, 32'(evq[0].data), 32'(exp_data));
      chk_rng({name, " latency"}, evq[0].cyc - e0, LAT_NOM - 1, LAT_NOM + 1);
      if (evq[0].kind == K_VALID) begin
        if (chk_sp)
          chk_rng({name, " spacing"}, evq[0].cyc - last_valid_cyc, NBITS * CPB - 1, NBITS * CPB + 1);
        last_valid_cyc = evq[0].cyc;
      end
    end
    evq.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         par_ok;
    int         gap;
    bit         watch;
    bit         spacing;
    int         exp_kind;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] d, input bit s, input bit p, input int g,
                              input bit w, input bit sp, input int k, input logic [7:0] ed);
    vec_t v;
    v.data = d; v.stop_ok = s; v.par_ok = p; v.gap = g; v.watch = w;
    v.spacing = sp; v.exp_kind = k; v.exp_data = ed;
    return v;
  endfunction

  initial begin
    int e0;
    int kind;
    logic [7:0] d;
    bit s;
    bit p;
    int g;

    // Directed vectors with hand-computed expectations.
    vecs.push_back(mk(8'h55, 1, 1, 1, 1, 0, K_VALID, 8'h55));
    vecs.push_back(mk(8'hA5, 1, 1, 0, 0, 0, K_VALID, 8'hA5));  // back-to-back with the next frame
    vecs.push_back(mk(8'h3C, 1, 1, 2, 0, 1, K_VALID, 8'h3C));
    vecs.push_back(mk(8'hF0, 0, 1, 1, 0, 0, K_FERR,  8'h3C));  // bad stop: data held
    vecs.push_back(mk(8'h0F, 1, 1, 1, 0, 0, K_VALID, 8'h0F));
`ifdef UART_RX_PARITY_EN
    vecs.push_back(mk(8'h07, 1, 1, 1, 0, 0, K_VALID, 8'h07));
    vecs.push_back(mk(8'h07, 1, 0, 1, 0, 0, K_PERR,  8'h07));
`endif

    // Reset state.
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Table-driven frames.
    for (int i = 0; i < vecs.size(); i++) begin
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].par_ok, vecs[i].gap, vecs[i].watch, e0);
      check_frame($sformatf("vec%0d", i), e0, vecs[i].exp_kind, vecs[i].exp_data, vecs[i].spacing);
      if (vecs[i].watch) chk("vec_busy_during_frame", 32'(busy_drops), 32'd0);
    end
    model_last = vecs[vecs.size() - 1].exp_data;

    // Short low pulse: glitch rejected, busy drops again, then a normal frame.
    e0 = cyc + 1;
    bus.rx = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("glitch busy_high", 32'(bus.rx_busy), 32'd1);
    repeat (44) @(posedge clk);
    #1;
    bus.rx = 1'b1;
    repeat (e0 + HALF + 3 - cyc) @(posedge clk);
    #1;
    chk("glitch busy_low", 32'(bus.rx_busy), 32'd0);
    repeat (2 * CPB) @(posedge clk);
    #1;
    chk("glitch strobe_count", 32'(evq.size()), 32'd0);
    evq.delete();
    send_frame(8'h81, 1, 1, 1, 0, e0);
    check_frame("after_glitch", e0, K_VALID, 8'h81, 0);

    // Reset during data bit 4 of 0xC3: the frame is dropped and the outputs clear.
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    bus.rx = d[4];
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("midframe_reset");
    rst_n = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    chk("midframe_reset strobe_count", 32'(evq.size()), 32'd0);
    evq.delete();
    send_frame(8'h12, 1, 1, 1, 0, e0);
    check_frame("after_reset", e0, K_VALID, 8'h12, 0);
    model_last = 8'h12;

    // Random frames checked against the frame-level model.
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
      p = ($urandom_range(0, 3) != 0);
`else
      p = 1'b1;
`endif
      g = s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      // A bad stop bit wins, then a parity mismatch; otherwise the byte is accepted.
      if (!s)      kind = K_FERR;
      else if (!p) kind = K_PERR;
      else begin
        kind = K_VALID;
        model_last = d;
      end
      send_frame(d, s, p, g, 0, e0);
      check_frame($sformatf("rand%0d_%02h", i, d), e0, kind, model_last, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
